// File: rtl/data_ram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_ram_ctrl                                                    |
// | Wait-stated word RAM responder for MEM-stage loads/stores.       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module data_ram_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        stall_req_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic               r_oor;
    logic [3:0]         r_sel;
    logic [ADDR_W-1:0]  r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH];

    logic               w_in_oor;
    logic               w_we;
    logic               w_oor;
    logic [3:0]         w_sel;
    logic [ADDR_W-1:0]  w_idx;
    logic [31:0]        w_wdata;
    logic               w_commit;
    logic               w_unused_lsbs;

    assign w_in_oor      = |addr_i[31:ADDR_W+2];
    assign w_unused_lsbs = &{1'b0, addr_i[1:0]};

    // With zero wait states the commit edge is the capture edge, so the
    // live inputs feed the RAM directly while still in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_we         = r_we;
        w_oor        = r_oor;
        w_sel        = r_sel;
        w_idx        = r_idx;
        w_wdata      = r_wdata;
        case (r_state)
            S_IDLE: begin
                w_we    = we_i;
                w_oor   = w_in_oor;
                w_sel   = sel_i;
                w_idx   = addr_i[ADDR_W+1:2];
                w_wdata = data_i;
                if (ce_i) begin
                    w_state_next = (WAIT_CYCLES > 0) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (int'(r_cnt) >= WAIT_CYCLES - 1) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_commit = (w_state_next == S_DONE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_sel   <= 4'h0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (ce_i) begin
                    r_we    <= we_i;
                    r_oor   <= w_in_oor;
                    r_sel   <= sel_i;
                    r_idx   <= addr_i[ADDR_W+1:2];
                    r_wdata <= data_i;
                end
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit && !w_we) begin
                r_rdata <= w_oor ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    // Lane k of the word is data[8k+7:8k]; sel bit 3 is the MSB lane.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_oor) begin
            for (int k = 0; k < 4; k++) begin
                if (w_sel[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign data_o      = r_rdata;
    assign ready_o     = (r_state == S_DONE);
    assign err_o       = ready_o & r_oor;
    assign stall_req_o = ce_i & ~ready_o;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_ram_ctrl                                                 |
// | Directed bench for data_ram_ctrl (WAIT_CYCLES=2 and 0 builds).   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ready, err, stall;
    logic        ce0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  sel0;
    logic [31:0] rdata0;
    logic        ready0, err0, stall0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr),
        .sel_i(sel), .data_i(wdata), .data_o(rdata), .ready_o(ready),
        .err_o(err), .stall_req_o(stall)
    );

    data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0),
        .sel_i(sel0), .data_i(wdata0), .data_o(rdata0), .ready_o(ready0),
        .err_o(err0), .stall_req_o(stall0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the start of an IDLE cycle; returns one cycle after DONE.
    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        lat = -1; rd = 32'hX; e = 1'bX;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c; rd = rdata; e = err;
                break;
            end
            @(posedge clk); #1;
        end
        ce = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic [7:0]  sp, rp;
        int          cnt;

        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; wdata0 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_ready", ready, 0);
        check_val("rst_err",   err,   0);
        check_val("rst_data",  rdata, 32'h0);
        check_val("rst_stall", stall, 0);
        @(posedge clk); #1;

        // Full-word write then read back
        xact(1'b1, 32'h10, 4'hF, 32'h11223344, rd, e, lat);
        check_val("wr_lat", 32'(lat), 3);
        check_val("wr_err", e, 0);
        xact(1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
        check_val("rd_lat",  32'(lat), 3);
        check_val("rd_data", rd, 32'h11223344);
        check_val("rd_err",  e, 0);

        // Single-lane write; data_o must hold through it
        xact(1'b1, 32'h11, 4'b0100, 32'hAAAAAAAA, rd, e, lat);
        check_val("hold_data", rdata, 32'h11223344);
        xact(1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
        check_val("lane_data", rd, 32'h11AA3344);
        xact(1'b1, 32'h10, 4'b0000, 32'h55555555, rd, e, lat);
        check_val("sel0_lat", 32'(lat), 3);
        xact(1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
        check_val("sel0_data", rd, 32'h11AA3344);

        // ce held high across two back-to-back reads
        ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
        sp = '0; rp = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sp = {sp[6:0], stall};
            rp = {rp[6:0], ready};
            if (c == 7) check_val("b2b_data", rdata, 32'h11AA3344);
            @(posedge clk); #1;
        end
        ce = 1'b0;
        check_val("b2b_stall", sp, 8'b1110_1110);
        check_val("b2b_ready", rp, 8'b0001_0001);
        @(posedge clk); #1;

        // Out-of-range write must not alias onto word 0
        xact(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, e, lat);
        xact(1'b1, 32'h00001000, 4'hF, 32'hDEADBEEF, rd, e, lat);
        check_val("oor_wr_err", e, 1);
        check_val("oor_wr_lat", 32'(lat), 3);
        xact(1'b0, 32'h0, 4'hF, 32'h0, rd, e, lat);
        check_val("word0_data", rd, 32'hCAFEF00D);
        check_val("word0_err",  e, 0);
        xact(1'b0, 32'h00001000, 4'hF, 32'h0, rd, e, lat);
        check_val("oor_rd_data", rd, 32'h0);
        check_val("oor_rd_err",  e, 1);

        // Reset in first BUSY cycle aborts the write
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst = 1'b1; ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cnt += int'(ready);
            @(posedge clk); #1;
        end
        check_val("abort_ready", 32'(cnt), 0);
        xact(1'b0, 32'h20, 4'hF, 32'h0, rd, e, lat);
        check_val("abort_lat",  32'(lat), 3);
        check_val("abort_data", rd, 32'h0);

        // ce dropped right after acceptance
        ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
        @(posedge clk); #1;
        ce = 1'b0;
        lat = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) check_val("drop_stall", stall, 0);
            if (ready) begin
                lat = c;
                check_val("drop_data", rdata, 32'h11AA3344);
                break;
            end
            @(posedge clk); #1;
        end
        check_val("drop_lat", 32'(lat), 3);
        @(posedge clk); #1;

        // Zero-wait-state build
        ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; sel0 = 4'hF; wdata0 = 32'h12345678;
        @(negedge clk);
        check_val("w0_wr_t0_ready", ready0, 0);
        check_val("w0_wr_t0_stall", stall0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("w0_wr_t1_ready", ready0, 1);
        check_val("w0_wr_t1_stall", stall0, 0);
        check_val("w0_wr_err", err0, 0);
        ce0 = 1'b0;
        @(posedge clk); #1;
        ce0 = 1'b1; we0 = 1'b0;
        @(negedge clk);
        check_val("w0_rd_t0_ready", ready0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("w0_rd_t1_ready", ready0, 1);
        check_val("w0_rd_data", rdata0, 32'h12345678);
        ce0 = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
